// File: rtl/player_pkg.sv
// Shared types and default constants for the player motion controller.
package player_pkg;

    localparam int unsigned HOR_PIXELS    = 640;
    localparam int unsigned PLAYER_WIDTH  = 32;
    localparam int unsigned MAX_SPEED     = 6;
    localparam int unsigned ACCEL_TICKS   = 4;
    localparam int unsigned FIRE_COOLDOWN = 20;
    localparam int unsigned SPEED_W       = 4;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic {
        ST_IDLE,
        ST_MOVE
    } motion_state_t;

endpackage

// File: rtl/player_motion_ctl_tick_gen.sv
// Free-running divider with a registered one-cycle strobe after each full period.
module tick_gen #(
    parameter int unsigned DIV = 650000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/player_motion_ctl.sv
// Player x-position controller: tick-paced acceleration ramp, edge clamping,
// freeze input and edge-triggered fire with cooldown.
module player_motion_ctl #(
    parameter int unsigned PLAYER_WIDTH  = player_pkg::PLAYER_WIDTH,
    parameter int unsigned XPOS_W        = 12,
    parameter int unsigned TICK_DIV      = 650000,
    parameter int unsigned MIN_SPEED     = 1,
    parameter int unsigned MAX_SPEED     = player_pkg::MAX_SPEED,
    parameter int unsigned ACCEL_TICKS   = player_pkg::ACCEL_TICKS,
    parameter int unsigned FIRE_COOLDOWN = player_pkg::FIRE_COOLDOWN,
    parameter int unsigned MIN_X         = 0,
    parameter int unsigned MAX_X         = player_pkg::HOR_PIXELS - PLAYER_WIDTH,
    parameter int unsigned INIT_X        = player_pkg::HOR_PIXELS / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              button_left,
    input  logic              button_right,
    input  logic              button_fire,
    output logic [XPOS_W-1:0] xpos,
    output logic [3:0]        speed,
    output logic              moving,
    output logic              fire_pulse,
    output logic              tick
);

    import player_pkg::*;

    localparam int unsigned POS_W  = XPOS_W + 1;
    localparam int unsigned ACC_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam int unsigned COOL_W = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

    motion_state_t       state_q, state_d;
    dir_t                last_dir_q, last_dir_d;
    dir_t                dir_c;
    logic [XPOS_W-1:0]   xpos_q, xpos_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [COOL_W-1:0]   cool_q, cool_d;
    logic                moving_q, moving_d;
    logic                fire_pulse_q, fire_pulse_d;
    logic                fire_prev_q, fire_prev_d;
    logic [POS_W-1:0]    pos_w, spd_w;
    logic                tick_c;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_c)
    );

    always_comb begin
        if (button_left && !button_right) begin
            dir_c = DIR_LEFT;
        end else if (button_right && !button_left) begin
            dir_c = DIR_RIGHT;
        end else begin
            dir_c = DIR_NONE;
        end
    end

    // Motion FSM, ramp and clamped position; all motion work happens on tick.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        xpos_d     = xpos_q;
        speed_d    = speed_q;
        acc_d      = acc_q;
        pos_w      = {1'b0, xpos_q};
        spd_w      = '0;

        if (!enable) begin
            state_d    = ST_IDLE;
            last_dir_d = DIR_NONE;
            speed_d    = '0;
            acc_d      = '0;
        end else if (tick_c) begin
            last_dir_d = dir_c;
            if (dir_c == DIR_NONE) begin
                state_d = ST_IDLE;
                speed_d = '0;
                acc_d   = '0;
            end else if (dir_c != last_dir_q || state_q == ST_IDLE) begin
                state_d = ST_MOVE;
                speed_d = SPEED_W'(MIN_SPEED);
                acc_d   = '0;
            end else if (acc_q == ACC_W'(ACCEL_TICKS - 1)) begin
                acc_d   = '0;
                speed_d = (speed_q >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                           : speed_q + SPEED_W'(1);
            end else begin
                acc_d = acc_q + ACC_W'(1);
            end

            // One extra bit keeps the edge comparisons free of wraparound.
            spd_w = POS_W'(speed_d);
            if (dir_c == DIR_LEFT) begin
                if (pos_w < POS_W'(MIN_X) + spd_w) begin
                    xpos_d = XPOS_W'(MIN_X);
                end else begin
                    xpos_d = XPOS_W'(pos_w - spd_w);
                end
            end else if (dir_c == DIR_RIGHT) begin
                if (pos_w + spd_w > POS_W'(MAX_X)) begin
                    xpos_d = XPOS_W'(MAX_X);
                end else begin
                    xpos_d = XPOS_W'(pos_w + spd_w);
                end
            end
        end

        moving_d = (state_d == ST_MOVE);
    end

    // Fire edge detect; the cooldown keeps counting down even while frozen.
    always_comb begin
        fire_prev_d  = button_fire;
        fire_pulse_d = 1'b0;
        cool_d       = cool_q;
        if (enable && button_fire && !fire_prev_q && cool_q == '0) begin
            fire_pulse_d = 1'b1;
            cool_d       = COOL_W'(FIRE_COOLDOWN);
        end else if (tick_c && cool_q != '0) begin
            cool_d = cool_q - COOL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_dir_q   <= DIR_NONE;
            xpos_q       <= XPOS_W'(INIT_X);
            speed_q      <= '0;
            acc_q        <= '0;
            cool_q       <= '0;
            moving_q     <= 1'b0;
            fire_pulse_q <= 1'b0;
            fire_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_dir_q   <= last_dir_d;
            xpos_q       <= xpos_d;
            speed_q      <= speed_d;
            acc_q        <= acc_d;
            cool_q       <= cool_d;
            moving_q     <= moving_d;
            fire_pulse_q <= fire_pulse_d;
            fire_prev_q  <= fire_prev_d;
        end
    end

    assign xpos       = xpos_q;
    assign speed      = speed_q;
    assign moving     = moving_q;
    assign fire_pulse = fire_pulse_q;
    assign tick       = tick_c;

endmodule

// File: tb/tb_player_motion_ctl.sv
// Scoreboard bench for player_motion_ctl with a short tick period and small play field.
module tb_player_motion_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        button_left;
    logic        button_right;
    logic        button_fire;
    logic [11:0] xpos;
    logic [3:0]  speed;
    logic        moving;
    logic        fire_pulse;
    logic        tick;

    typedef struct {
        int unsigned x;
        int unsigned s;
        int unsigned m;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned fire_cnt = 0;

    player_motion_ctl #(
        .XPOS_W        (12),
        .TICK_DIV      (4),
        .MIN_SPEED     (1),
        .MAX_SPEED     (3),
        .ACCEL_TICKS   (2),
        .FIRE_COOLDOWN (3),
        .MIN_X         (0),
        .MAX_X         (100),
        .INIT_X        (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .button_left  (button_left),
        .button_right (button_right),
        .button_fire  (button_fire),
        .xpos         (xpos),
        .speed        (speed),
        .moving       (moving),
        .fire_pulse   (fire_pulse),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fire_pulse) fire_cnt <= fire_cnt + 1;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Speed after k consecutive same-direction ticks: 1,1,2,2,3,3,...
    function automatic int unsigned ramp(input int unsigned k);
        int unsigned s;
        s = 1 + k / 2;
        return (s > 3) ? 3 : s;
    endfunction

    // Drive inputs for the next tick, queue the expected outcome, compare after it lands.
    task automatic do_tick(input logic l, input logic r, input logic en,
                           input int unsigned ex, input int unsigned es, input int unsigned em);
        exp_t e;
        int   n;
        button_left  = l;
        button_right = r;
        enable       = en;
        e.x = ex;
        e.s = es;
        e.m = em;
        exp_q.push_back(e);
        n = 0;
        while (!tick && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", 32'(tick), 1);
        @(negedge clk);
        e = exp_q.pop_front();
        check("xpos", 32'(xpos), e.x);
        check("speed", 32'(speed), e.s);
        check("moving", 32'(moving), e.m);
    endtask

    task automatic wait_ticks(input int unsigned n);
        int unsigned seen;
        int unsigned budget;
        seen   = 0;
        budget = 0;
        while (seen < n && budget < n * 8 + 8) begin
            @(negedge clk);
            if (tick) seen++;
            budget++;
        end
        check("tick_wait", seen, n);
    endtask

    initial begin
        int unsigned rx[8];
        int unsigned rs[8];
        int unsigned x;
        int unsigned s;
        int unsigned fc;
        int          last_tick;
        int unsigned n_ticks;
        logic        prev_tick;

        rx = '{51, 52, 54, 56, 59, 62, 65, 68};
        rs = '{1, 1, 2, 2, 3, 3, 3, 3};

        rst          = 1'b1;
        enable       = 1'b1;
        button_left  = 1'b0;
        button_right = 1'b0;
        button_fire  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_xpos", 32'(xpos), 50);
        check("rst_speed", 32'(speed), 0);
        check("rst_moving", 32'(moving), 0);
        check("rst_fire", 32'(fire_pulse), 0);
        check("rst_tick", 32'(tick), 0);
        rst = 1'b0;

        // Idle: tick period and width, position untouched.
        last_tick = -1;
        n_ticks   = 0;
        prev_tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick) begin
                n_ticks++;
                check("tick_width", 32'(prev_tick), 0);
                if (last_tick >= 0) check("tick_period", 32'(i - last_tick), 4);
                last_tick = i;
            end
            prev_tick = tick;
        end
        check("tick_count", n_ticks, 5);
        check("idle_xpos", 32'(xpos), 50);
        check("idle_speed", 32'(speed), 0);

        // Accelerating right from rest.
        for (int k = 0; k < 8; k++) do_tick(1'b0, 1'b1, 1'b1, rx[k], rs[k], 1);

        // Keep going right into the right clamp.
        x = 68;
        for (int k = 0; k < 12; k++) begin
            x = (x + 3 > 100) ? 100 : x + 3;
            do_tick(1'b0, 1'b1, 1'b1, x, 3, 1);
        end

        // Instant reversal restarts the ramp, then run into the left clamp.
        x = 100;
        for (int k = 0; k < 38; k++) begin
            s = ramp(32'(k));
            x = (x < s) ? 0 : x - s;
            do_tick(1'b1, 1'b0, 1'b1, x, s, 1);
        end

        // Both buttons count as no direction.
        do_tick(1'b1, 1'b1, 1'b1, 0, 0, 0);
        do_tick(1'b0, 1'b0, 1'b0 | 1'b1, 0, 0, 0);

        // Fire edge, discarded edge during cooldown.
        @(negedge clk);
        fc = fire_cnt;
        button_fire = 1'b1;
        @(negedge clk);
        check("fire_first", 32'(fire_pulse), 1);
        @(negedge clk);
        check("fire_width", 32'(fire_pulse), 0);
        button_fire = 1'b0;
        @(negedge clk);
        button_fire = 1'b1;
        repeat (3) @(negedge clk);
        check("fire_cooldown_block", fire_cnt - fc, 1);
        button_fire = 1'b0;

        // After cooldown a fresh edge fires; holding never repeats.
        wait_ticks(4);
        fc = fire_cnt;
        button_fire = 1'b1;
        @(negedge clk);
        check("fire_after_cooldown", 32'(fire_pulse), 1);
        wait_ticks(10);
        button_fire = 1'b0;
        repeat (2) @(negedge clk);
        check("fire_hold_single", fire_cnt - fc, 1);

        // No shot while frozen.
        wait_ticks(4);
        enable = 1'b0;
        @(negedge clk);
        fc = fire_cnt;
        button_fire = 1'b1;
        repeat (3) @(negedge clk);
        check("fire_disabled", fire_cnt - fc, 0);
        button_fire = 1'b0;
        @(negedge clk);

        // Ramp to speed 2, freeze, re-enable restarts at minimum speed.
        do_tick(1'b0, 1'b1, 1'b1, 1, 1, 1);
        do_tick(1'b0, 1'b1, 1'b1, 2, 1, 1);
        do_tick(1'b0, 1'b1, 1'b1, 4, 2, 1);
        for (int k = 0; k < 3; k++) do_tick(1'b0, 1'b1, 1'b0, 4, 0, 0);
        do_tick(1'b0, 1'b1, 1'b1, 5, 1, 1);

        // Reset mid-move.
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_xpos", 32'(xpos), 50);
        check("rst_mid_speed", 32'(speed), 0);
        check("rst_mid_moving", 32'(moving), 0);
        rst = 1'b0;
        button_right = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
